reg_scoreboard: RTL and testbench

Hazard scoreboard for the RV32I integer register file. Tracks outstanding writes to each architectural register from multi-cycle producers (loads, CSR reads, long-latency ops). Holds the decode/issue stage with a valid/ready handshake until the source operands are final and the destination's in-flight count has headroom. Sits between decode and the register file read stage; writeback notifies it when it drives the register file write port.

---
 rtl/reg_scoreboard_if.sv | 39 +++
 rtl/reg_scoreboard.sv | 89 ++++++++
 tb/tb_reg_scoreboard.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_scoreboard_if.sv
// Issue, writeback and status bundle between decode/writeback
// and the register hazard scoreboard.
`ifndef XADDR
`define XADDR 5
`endif

interface reg_scoreboard_if;
  logic               i_issue_valid;
  logic               o_issue_ready;
  logic [`XADDR-1:0]  i_rs1_addr;
  logic               i_rs1_used;
  logic [`XADDR-1:0]  i_rs2_addr;
  logic               i_rs2_used;
  logic [`XADDR-1:0]  i_rd_addr;
  logic               i_rd_wen;
  logic               i_wb_valid;
  logic [`XADDR-1:0]  i_wb_addr;
  logic               i_flush;
  logic [31:0]        or_busy;
  logic [6:0]         or_outstanding;
  logic [31:0]        or_stall_cycles;
  logic               or_wb_error;

  modport master (
    output i_issue_valid, i_rs1_addr, i_rs1_used,
    output i_rs2_addr, i_rs2_used, i_rd_addr, i_rd_wen,
    output i_wb_valid, i_wb_addr, i_flush,
    input  o_issue_ready, or_busy, or_outstanding,
    input  or_stall_cycles, or_wb_error
  );

  modport slave (
    input  i_issue_valid, i_rs1_addr, i_rs1_used,
    input  i_rs2_addr, i_rs2_used, i_rd_addr, i_rd_wen,
    input  i_wb_valid, i_wb_addr, i_flush,
    output o_issue_ready, or_busy, or_outstanding,
    output or_stall_cycles, or_wb_error
  );
endinterface

// File: rtl/reg_scoreboard.sv
// RV32I register hazard scoreboard: per-register in-flight
// write counters gating issue on RAW and WAW-headroom hazards.
`ifndef XADDR
`define XADDR 5
`endif

module reg_scoreboard #(
  parameter int MAX_PENDING = 3
) (
  input logic              i_clk,
  input logic              i_rst,
  reg_scoreboard_if.slave  sb
);

  logic [31:0][1:0] cnt;
  logic [31:0][1:0] cnt_nxt;
  logic [31:0]      busy_nxt;
  logic             raw1;
  logic             raw2;
  logic             waw_full;
  logic             ready;
  logic             fire;
  logic             inc_any;
  logic             dec_any;
  logic             wb_orphan;
  logic             stall;
  logic [6:0]       outst_nxt;

  always_comb begin
    raw1 = sb.i_rs1_used && (sb.i_rs1_addr != '0)
        && (cnt[sb.i_rs1_addr] != 2'd0);
    raw2 = sb.i_rs2_used && (sb.i_rs2_addr != '0)
        && (cnt[sb.i_rs2_addr] != 2'd0);
    waw_full = sb.i_rd_wen && (sb.i_rd_addr != '0)
        && (cnt[sb.i_rd_addr] == 2'(MAX_PENDING));
    ready = !sb.i_flush && !raw1 && !raw2 && !waw_full;
    fire  = sb.i_issue_valid && ready;
    inc_any = fire && sb.i_rd_wen && (sb.i_rd_addr != '0);
    dec_any = sb.i_wb_valid && (sb.i_wb_addr != '0)
        && (cnt[sb.i_wb_addr] != 2'd0);
    wb_orphan = sb.i_wb_valid && (sb.i_wb_addr != '0)
        && (cnt[sb.i_wb_addr] == 2'd0);
    stall = sb.i_issue_valid && !ready;
  end

  assign sb.o_issue_ready = ready;

  // Same-register issue and retire cancel out, so the
  // running total can follow inc_any/dec_any directly.
  always_comb begin
    cnt_nxt  = '0;
    busy_nxt = '0;
    for (int r = 1; r < 32; r++) begin
      cnt_nxt[r] = cnt[r];
      if (inc_any && (sb.i_rd_addr == 5'(r))
          && !(dec_any && (sb.i_wb_addr == 5'(r))))
        cnt_nxt[r] = cnt[r] + 2'd1;
      else if (dec_any && (sb.i_wb_addr == 5'(r))
          && !(inc_any && (sb.i_rd_addr == 5'(r))))
        cnt_nxt[r] = cnt[r] - 2'd1;
      if (sb.i_flush)
        cnt_nxt[r] = 2'd0;
      busy_nxt[r] = (cnt_nxt[r] != 2'd0);
    end
    outst_nxt = sb.or_outstanding
        + 7'(inc_any) - 7'(dec_any);
    if (sb.i_flush)
      outst_nxt = '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt                <= '0;
      sb.or_busy         <= '0;
      sb.or_outstanding  <= '0;
      sb.or_stall_cycles <= '0;
      sb.or_wb_error     <= 1'b0;
    end else begin
      cnt               <= cnt_nxt;
      sb.or_busy        <= busy_nxt;
      sb.or_outstanding <= outst_nxt;
      if (stall && (sb.or_stall_cycles != '1))
        sb.or_stall_cycles <= sb.or_stall_cycles + 32'd1;
      if (wb_orphan)
        sb.or_wb_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: reset, RAW, x0,
// WAW saturation, simultaneous issue/retire and flush.
module tb_reg_scoreboard;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   exp_stall = 0;

  reg_scoreboard_if sbif ();

  reg_scoreboard #(.MAX_PENDING(3)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .sb    (sbif.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sbif.i_issue_valid = 1'b0;
    sbif.i_rs1_addr    = '0;
    sbif.i_rs1_used    = 1'b0;
    sbif.i_rs2_addr    = '0;
    sbif.i_rs2_used    = 1'b0;
    sbif.i_rd_addr     = '0;
    sbif.i_rd_wen      = 1'b0;
    sbif.i_wb_valid    = 1'b0;
    sbif.i_wb_addr     = '0;
    sbif.i_flush       = 1'b0;
  endtask

  task automatic issue(input logic [4:0] rd);
    idle();
    sbif.i_issue_valid = 1'b1;
    sbif.i_rd_addr     = rd;
    sbif.i_rd_wen      = 1'b1;
  endtask

  task automatic retire(input logic [4:0] a);
    idle();
    sbif.i_wb_valid = 1'b1;
    sbif.i_wb_addr  = a;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sbif.i_issue_valid = 1'($urandom_range(0, 1));
      sbif.i_rs1_addr    = 5'($urandom_range(0, 31));
      sbif.i_rs1_used    = 1'($urandom_range(0, 1));
      sbif.i_rs2_addr    = 5'($urandom_range(0, 31));
      sbif.i_rs2_used    = 1'($urandom_range(0, 1));
      sbif.i_rd_addr     = 5'($urandom_range(0, 31));
      sbif.i_rd_wen      = 1'($urandom_range(0, 1));
      sbif.i_wb_valid    = 1'($urandom_range(0, 1));
      sbif.i_wb_addr     = 5'($urandom_range(0, 31));
      sbif.i_flush       = 1'b0;
      tick();
    end
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (sbif.or_busy !== 32'h0) begin
      errors++;
      $display("FAIL rst_busy got %h exp 0", sbif.or_busy);
    end
    checks++;
    if (sbif.or_outstanding !== 7'd0) begin
      errors++;
      $display("FAIL rst_outst got %0d exp 0", sbif.or_outstanding);
    end
    checks++;
    if (sbif.or_stall_cycles !== 32'd0) begin
      errors++;
      $display("FAIL rst_stall got %0d exp 0", sbif.or_stall_cycles);
    end
    checks++;
    if (sbif.or_wb_error !== 1'b0) begin
      errors++;
      $display("FAIL rst_wberr got %b exp 0", sbif.or_wb_error);
    end
    checks++;
    if (sbif.o_issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_ready got %b exp 1", sbif.o_issue_ready);
    end
  endtask

  task automatic test_raw();
    issue(5'd5);
    #1;
    checks++;
    if (sbif.o_issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL raw_prod_ready got %b exp 1", sbif.o_issue_ready);
    end
    tick();
    idle();
    sbif.i_issue_valid = 1'b1;
    sbif.i_rs1_addr    = 5'd5;
    sbif.i_rs1_used    = 1'b1;
    #1;
    checks++;
    if (sbif.or_busy !== 32'h0000_0020) begin
      errors++;
      $display("FAIL raw_busy got %h exp 00000020", sbif.or_busy);
    end
    for (int c = 0; c < 3; c++) begin
      if (c == 2) begin
        sbif.i_wb_valid = 1'b1;
        sbif.i_wb_addr  = 5'd5;
      end
      #1;
      checks++;
      if (sbif.o_issue_ready !== 1'b0) begin
        errors++;
        $display("FAIL raw_stall%0d got %b exp 0", c, sbif.o_issue_ready);
      end
      tick();
    end
    exp_stall = 3;
    sbif.i_wb_valid = 1'b0;
    #1;
    checks++;
    if (sbif.o_issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL raw_release got %b exp 1", sbif.o_issue_ready);
    end
    checks++;
    if (sbif.or_stall_cycles !== 32'(exp_stall)) begin
      errors++;
      $display("FAIL raw_stallcnt got %0d exp %0d",
               sbif.or_stall_cycles, exp_stall);
    end
    tick();
    idle();
  endtask

  task automatic test_x0();
    issue(5'd0);
    tick();
    idle();
    #1;
    checks++;
    if (sbif.or_busy !== 32'h0 || sbif.or_outstanding !== 7'd0) begin
      errors++;
      $display("FAIL x0_busy got %h/%0d exp 0/0",
               sbif.or_busy, sbif.or_outstanding);
    end
    issue(5'd7);
    tick();
    idle();
    sbif.i_rs2_addr = 5'd7;
    sbif.i_rs2_used = 1'b0;
    #1;
    checks++;
    if (sbif.o_issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL x0_unused got %b exp 1", sbif.o_issue_ready);
    end
    sbif.i_rs2_used = 1'b1;
    #1;
    checks++;
    if (sbif.o_issue_ready !== 1'b0) begin
      errors++;
      $display("FAIL x0_used got %b exp 0", sbif.o_issue_ready);
    end
    retire(5'd7);
    tick();
    idle();
    #1;
    checks++;
    if (sbif.or_outstanding !== 7'd0 || sbif.or_busy !== 32'h0) begin
      errors++;
      $display("FAIL x0_clean got %0d/%h exp 0/0",
               sbif.or_outstanding, sbif.or_busy);
    end
  endtask

  task automatic test_waw();
    for (int i = 0; i < 3; i++) begin
      issue(5'd9);
      tick();
    end
    idle();
    #1;
    checks++;
    if (sbif.or_outstanding !== 7'd3) begin
      errors++;
      $display("FAIL waw_outst got %0d exp 3", sbif.or_outstanding);
    end
    issue(5'd9);
    #1;
    checks++;
    if (sbif.o_issue_ready !== 1'b0) begin
      errors++;
      $display("FAIL waw_full got %b exp 0", sbif.o_issue_ready);
    end
    sbif.i_wb_valid = 1'b1;
    sbif.i_wb_addr  = 5'd9;
    tick();
    exp_stall++;
    sbif.i_wb_valid = 1'b0;
    #1;
    checks++;
    if (sbif.o_issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL waw_room got %b exp 1", sbif.o_issue_ready);
    end
    tick();
    idle();
    #1;
    checks++;
    if (sbif.or_outstanding !== 7'd3
        || sbif.or_busy !== 32'h0000_0200) begin
      errors++;
      $display("FAIL waw_refill got %0d/%h exp 3/00000200",
               sbif.or_outstanding, sbif.or_busy);
    end
    for (int i = 0; i < 3; i++) begin
      retire(5'd9);
      tick();
    end
    idle();
    #1;
    checks++;
    if (sbif.or_outstanding !== 7'd0 || sbif.or_wb_error !== 1'b0) begin
      errors++;
      $display("FAIL waw_drain got %0d/%b exp 0/0",
               sbif.or_outstanding, sbif.or_wb_error);
    end
  endtask

  task automatic test_simul();
    issue(5'd3);
    tick();
    issue(5'd3);
    sbif.i_wb_valid = 1'b1;
    sbif.i_wb_addr  = 5'd3;
    tick();
    idle();
    #1;
    checks++;
    if (sbif.or_outstanding !== 7'd1
        || sbif.or_busy !== 32'h0000_0008) begin
      errors++;
      $display("FAIL sim_same got %0d/%h exp 1/00000008",
               sbif.or_outstanding, sbif.or_busy);
    end
    retire(5'd3);
    tick();
    retire(5'd0);
    tick();
    #1;
    checks++;
    if (sbif.or_wb_error !== 1'b0 || sbif.or_outstanding !== 7'd0) begin
      errors++;
      $display("FAIL sim_x0wb got %b/%0d exp 0/0",
               sbif.or_wb_error, sbif.or_outstanding);
    end
    retire(5'd4);
    tick();
    idle();
    tick();
    checks++;
    if (sbif.or_wb_error !== 1'b1) begin
      errors++;
      $display("FAIL sim_wberr got %b exp 1", sbif.or_wb_error);
    end
  endtask

  task automatic test_flush();
    logic [4:0] regs [5];
    regs = '{5'd1, 5'd2, 5'd10, 5'd20, 5'd31};
    foreach (regs[i]) begin
      issue(regs[i]);
      tick();
    end
    idle();
    #1;
    checks++;
    if (sbif.or_outstanding !== 7'd5
        || sbif.or_busy !== 32'h8010_0406) begin
      errors++;
      $display("FAIL fl_pre got %0d/%h exp 5/80100406",
               sbif.or_outstanding, sbif.or_busy);
    end
    issue(5'd6);
    sbif.i_wb_valid = 1'b1;
    sbif.i_wb_addr  = 5'd1;
    sbif.i_flush    = 1'b1;
    #1;
    checks++;
    if (sbif.o_issue_ready !== 1'b0) begin
      errors++;
      $display("FAIL fl_ready got %b exp 0", sbif.o_issue_ready);
    end
    tick();
    exp_stall++;
    idle();
    #1;
    checks++;
    if (sbif.or_busy !== 32'h0 || sbif.or_outstanding !== 7'd0) begin
      errors++;
      $display("FAIL fl_clear got %h/%0d exp 0/0",
               sbif.or_busy, sbif.or_outstanding);
    end
    checks++;
    if (sbif.or_stall_cycles !== 32'(exp_stall)) begin
      errors++;
      $display("FAIL fl_stall got %0d exp %0d",
               sbif.or_stall_cycles, exp_stall);
    end
    checks++;
    if (sbif.or_wb_error !== 1'b1) begin
      errors++;
      $display("FAIL fl_wberr got %b exp 1", sbif.or_wb_error);
    end
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();
    test_reset();
    test_raw();
    test_x0();
    test_waw();
    test_simul();
    test_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
